jtkiwi_romrq_buf: RTL

JTKIWI_ROMRQ_BUF -- requirements
Module: jtkiwi_romrq_buf

---
 rtl/jtkiwi_pkg.sv | 26 ++
 rtl/jtkiwi_romrq_buf.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/jtkiwi_pkg.sv
// Shared definitions for the kiwi ROM request line buffer.
package jtkiwi_pkg;

  localparam int LINE_BYTES = 4;
  localparam int LINE_BITS  = 8 * LINE_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Little-endian byte lane select out of a cached line
  function automatic logic [7:0] line_byte(input logic [LINE_BITS-1:0] line,
                                           input logic [1:0]           sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = line[7:0];
      2'd1:    b = line[15:8];
      2'd2:    b = line[23:16];
      default: b = line[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/jtkiwi_romrq_buf.sv
// Single-line read buffer between a byte-wide CPU ROM port and a 32-bit SDRAM port.
//
// state | meaning
// IDLE  | serve hits from the line, issue a line fill on a miss
// FILL  | SDRAM request outstanding; address held until sdram_ok
// DONE  | one-cycle settle after a fill, then back to IDLE to re-evaluate
module jtkiwi_romrq_buf
  import jtkiwi_pkg::*;
#(
  parameter int AW      = 17,
  parameter bit OKLATCH = 1'b1
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cpu_cs,
  input  logic [AW-1:0] cpu_addr,
  output logic [7:0]    cpu_data,
  output logic          cpu_ok,
  input  logic          flush,
  output logic          sdram_cs,
  output logic [AW-3:0] sdram_addr,
  input  logic [31:0]   sdram_data,
  input  logic          sdram_ok,
  output logic [7:0]    miss_cnt
);

  state_t                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [AW-3:0]         tag_q, tag_d;
  logic [LINE_BITS-1:0]  line_q, line_d;
  logic                  stale_q, stale_d;
  logic                  cpu_ok_q, cpu_ok_d;
  logic [7:0]            cpu_data_q, cpu_data_d;
  logic                  sdram_cs_q, sdram_cs_d;
  logic [AW-3:0]         sdram_addr_q, sdram_addr_d;
  logic [7:0]            miss_cnt_q, miss_cnt_d;
  // Remembers which address last got cpu_ok, so OKLATCH=0 can pulse once per access
  logic                  served_q, served_d;
  logic [AW-1:0]         ok_addr_q, ok_addr_d;

  logic                  hit;
  logic                  same_access;

  assign hit         = valid_q && (tag_q == cpu_addr[AW-1:2]);
  assign same_access = served_q && cpu_cs && (cpu_addr == ok_addr_q);

  // Next-state and next-output computation for the buffer FSM
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    line_d       = line_q;
    stale_d      = stale_q;
    cpu_ok_d     = 1'b0;
    cpu_data_d   = cpu_data_q;
    sdram_cs_d   = sdram_cs_q;
    sdram_addr_d = sdram_addr_q;
    miss_cnt_d   = miss_cnt_q;
    served_d     = same_access;
    ok_addr_d    = ok_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          // Flush wins over a coincident hit; the miss follows next cycle
          valid_d = 1'b0;
        end else if (cpu_cs && hit) begin
          cpu_data_d = line_byte(line_q, cpu_addr[1:0]);
          cpu_ok_d   = OKLATCH || !same_access;
          served_d   = 1'b1;
          ok_addr_d  = cpu_addr;
        end else if (cpu_cs) begin
          sdram_addr_d = cpu_addr[AW-1:2];
          sdram_cs_d   = 1'b1;
          if (miss_cnt_q != 8'hFF) miss_cnt_d = miss_cnt_q + 8'd1;
          state_d      = ST_FILL;
        end
      end
      ST_FILL: begin
        // The SDRAM transaction always runs to completion; flush only poisons it
        if (flush) begin
          stale_d = 1'b1;
          valid_d = 1'b0;
        end
        if (sdram_ok) begin
          if (!stale_q && !flush) begin
            line_d  = sdram_data;
            tag_d   = sdram_addr_q;
            valid_d = 1'b1;
          end
          sdram_cs_d = 1'b0;
          stale_d    = 1'b0;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        if (flush) valid_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops sdram_cs without waiting for a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      valid_q      <= 1'b0;
      tag_q        <= '0;
      line_q       <= '0;
      stale_q      <= 1'b0;
      cpu_ok_q     <= 1'b0;
      cpu_data_q   <= 8'd0;
      sdram_cs_q   <= 1'b0;
      sdram_addr_q <= '0;
      miss_cnt_q   <= 8'd0;
      served_q     <= 1'b0;
      ok_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      line_q       <= line_d;
      stale_q      <= stale_d;
      cpu_ok_q     <= cpu_ok_d;
      cpu_data_q   <= cpu_data_d;
      sdram_cs_q   <= sdram_cs_d;
      sdram_addr_q <= sdram_addr_d;
      miss_cnt_q   <= miss_cnt_d;
      served_q     <= served_d;
      ok_addr_q    <= ok_addr_d;
    end
  end

  assign cpu_ok     = cpu_ok_q;
  assign cpu_data   = cpu_data_q;
  assign sdram_cs   = sdram_cs_q;
  assign sdram_addr = sdram_addr_q;
  assign miss_cnt   = miss_cnt_q;

endmodule
